// File: rtl/rv_enc_pkg.sv
// Shared definitions for the RV32I instruction encoder / imem loader:
// descriptor kinds, opcodes, error codes and an immediate range helper.
package rv_enc_pkg;

  typedef enum logic [3:0] {
    KIND_LOAD   = 4'd0,
    KIND_ALUI   = 4'd1,
    KIND_ALUR   = 4'd2,
    KIND_STORE  = 4'd3,
    KIND_BRANCH = 4'd4,
    KIND_JAL    = 4'd5,
    KIND_JALR   = 4'd6,
    KIND_LUI    = 4'd7,
    KIND_AUIPC  = 4'd8
  } instr_kind_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_KIND = 2'b01;
  localparam logic [1:0] ERR_IMM  = 2'b10;
  localparam logic [1:0] ERR_WRAP = 2'b11;

  localparam logic [31:0] NOP = 32'h00000013;

  // True when v is representable as an nbits-wide two's complement value:
  // every bit from nbits-1 upward must equal the sign bit.
  function automatic logic fits_signed(input logic signed [31:0] v,
                                       input int unsigned nbits);
    logic signed [31:0] hi;
    hi = v >>> (nbits - 1);
    return (hi == 32'sd0) || (hi == -32'sd1);
  endfunction

endpackage

// File: rtl/imem_encoder_loader_if.sv
// Bus bundles for the loader: the descriptor stream coming in and the
// stallable instruction-memory write port going out.
interface desc_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        in_last;

  // Producer of descriptors (boot/test harness)
  modport master (
    output in_valid, in_kind, in_funct3, in_funct7b5,
           in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready
  );

  // Consumer of descriptors (the loader)
  modport slave (
    input  in_valid, in_kind, in_funct3, in_funct7b5,
           in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready
  );
endinterface

interface imem_wr_if #(
  parameter int ADDR_W = 10
);
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Write requester (the loader)
  modport master (
    output imem_we, imem_addr, imem_wdata,
    input  imem_ready
  );

  // Instruction memory
  modport slave (
    input  imem_we, imem_addr, imem_wdata,
    output imem_ready
  );
endinterface

// File: rtl/rv_enc_comb.sv
// Combinational RV32I encoder: builds the 32-bit word for one descriptor
// and flags unknown kinds and immediates that do not fit their field.
// Out-of-range immediates are still encoded (truncated) so the caller can
// write them and report the problem separately.
module rv_enc_comb
  import rv_enc_pkg::*;
(
  input  logic [3:0]         kind,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic signed [31:0] imm,
  output logic [31:0]        word,
  output logic               illegal,
  output logic               imm_bad
);

  logic is_shift;
  logic b30_shift;

  // Shift-immediate forms carry a 5-bit shamt; only SRAI/SRLI use bit 30.
  assign is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign b30_shift = (funct3 == 3'b101) ? funct7b5 : 1'b0;

  // Per-format field packing and immediate range check
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    imm_bad = 1'b0;
    case (kind)
      KIND_LOAD: begin
        word    = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        imm_bad = !fits_signed(imm, 12);
      end
      KIND_ALUI: begin
        if (is_shift) begin
          word    = {1'b0, b30_shift, 5'b00000, imm[4:0], rs1, funct3, rd, OP_ALUI};
          imm_bad = (imm < 32'sd0) || (imm > 32'sd31);
        end else begin
          word    = {imm[11:0], rs1, funct3, rd, OP_ALUI};
          imm_bad = !fits_signed(imm, 12);
        end
      end
      KIND_ALUR: begin
        word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_ALUR};
      end
      KIND_STORE: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        imm_bad = !fits_signed(imm, 12);
      end
      KIND_BRANCH: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        imm_bad = !fits_signed(imm, 13) || imm[0];
      end
      KIND_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        imm_bad = !fits_signed(imm, 21) || imm[0];
      end
      KIND_JALR: begin
        word    = {imm[11:0], rs1, funct3, rd, OP_JALR};
        imm_bad = !fits_signed(imm, 12);
      end
      KIND_LUI: begin
        word    = {imm[31:12], rd, OP_LUI};
        imm_bad = (imm[11:0] != 12'h000);
      end
      KIND_AUIPC: begin
        word    = {imm[31:12], rd, OP_AUIPC};
        imm_bad = (imm[11:0] != 12'h000);
      end
      default: begin
        word    = 32'h0000_0000;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imem_encoder_loader.sv
// Sequential instruction encoder and imem loader. Descriptors accepted on
// the stream are encoded, held in a single output register and written to
// consecutive word addresses; the first encoding or address-wrap problem
// of a session is latched for the harness to inspect.
module imem_encoder_loader
  import rv_enc_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  desc_if.slave             desc,
  imem_wr_if.master         imem,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state;
  logic              last_pending;
  logic              start_ok;
  logic              in_ready_int;
  logic              accept;
  logic              complete;

  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              enc_imm_bad;

  logic              we;
  logic [31:0]       wdata;
  logic              out_last;
  logic              out_illegal;
  logic              out_imm_bad;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   cnt;

  logic              err_r;
  logic [1:0]        code_r;
  logic [ADDR_W-1:0] eaddr_r;

  rv_enc_comb u_enc (
    .kind     (desc.in_kind),
    .funct3   (desc.in_funct3),
    .funct7b5 (desc.in_funct7b5),
    .rd       (desc.in_rd),
    .rs1      (desc.in_rs1),
    .rs2      (desc.in_rs2),
    .imm      (desc.in_imm),
    .word     (enc_word),
    .illegal  (enc_illegal),
    .imm_bad  (enc_imm_bad)
  );

  // start is ignored while a session is running
  assign start_ok     = start && ((state == S_IDLE) || (state == S_DONE));
  // Accept only while the output slot is free or draining this cycle,
  // and never after the final descriptor of the session was taken.
  assign in_ready_int = (state == S_RUN) && !last_pending && (!we || imem.imem_ready);
  assign accept       = desc.in_valid && in_ready_int;
  assign complete     = we && imem.imem_ready;

  // Session FSM: IDLE -> RUN on start, RUN -> DONE when the last word lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      last_pending <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          last_pending <= 1'b0;
          if (start_ok) state <= S_RUN;
        end
        S_RUN: begin
          if (accept && desc.in_last) last_pending <= 1'b1;
          if (complete && out_last) state <= S_DONE;
        end
        S_DONE: begin
          last_pending <= 1'b0;
          state        <= start_ok ? S_RUN : S_IDLE;
        end
        default: begin
          state        <= S_IDLE;
          last_pending <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load on accept, drop the request once it completes,
  // otherwise hold word and request stable through a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we          <= 1'b0;
      wdata       <= 32'h0000_0000;
      out_last    <= 1'b0;
      out_illegal <= 1'b0;
      out_imm_bad <= 1'b0;
    end else if (accept) begin
      we          <= 1'b1;
      wdata       <= enc_word;
      out_last    <= desc.in_last;
      out_illegal <= enc_illegal;
      out_imm_bad <= enc_imm_bad;
    end else if (complete) begin
      we          <= 1'b0;
    end
  end

  // Address and word counters advance on every completed write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= BASE_ADDR;
      cnt  <= '0;
    end else if (start_ok) begin
      addr <= BASE_ADDR;
      cnt  <= '0;
    end else if (complete) begin
      addr <= addr + ADDR_ONE;
      cnt  <= cnt + CNT_ONE;
    end
  end

  // First-error capture, evaluated as each word is written so err_addr is
  // the address that word actually landed at; later errors are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r   <= 1'b0;
      code_r  <= ERR_NONE;
      eaddr_r <= '0;
    end else if (start_ok) begin
      err_r   <= 1'b0;
      code_r  <= ERR_NONE;
      eaddr_r <= '0;
    end else if (complete && !err_r) begin
      if (out_illegal) begin
        err_r   <= 1'b1;
        code_r  <= ERR_KIND;
        eaddr_r <= addr;
      end else if (out_imm_bad) begin
        err_r   <= 1'b1;
        code_r  <= ERR_IMM;
        eaddr_r <= addr;
      end else if (addr == ADDR_MAX) begin
        err_r   <= 1'b1;
        code_r  <= ERR_WRAP;
        eaddr_r <= addr;
      end
    end
  end

  assign desc.in_ready   = in_ready_int;
  assign imem.imem_we    = we;
  assign imem.imem_addr  = addr;
  assign imem.imem_wdata = wdata;
  assign count           = cnt;
  assign done            = (state == S_DONE);
  assign err             = err_r;
  assign err_code        = code_r;
  assign err_addr        = eaddr_r;

endmodule

// File: doc/imem_encoder_loader.md
# imem_encoder_loader

Sequential RV32I instruction encoder and instruction-memory loader: the inverse of the core's control decoder. It accepts instruction descriptors (instruction kind, register fields, funct3/funct7b5, immediate) over a valid/ready stream. It encodes each one into a 32-bit RV32I word and writes it to consecutive instruction-memory addresses through a stallable write port. It is used by the boot/test harness to build programs in imem ahead of the in-order pipeline, and it reports encoding and address errors.

## Interface
- ADDR_W, 10, imem word-address width
- BASE_ADDR, 0, first word address written after `start`
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse; begins a load session (honoured only in IDLE or DONE)
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready
- in_kind  in  4  LOAD, ALUI, ALUR, STORE, BRANCH, JAL, JALR, LUI, AUIPC (enum in package)
- in_funct3  in  3  funct3 field
- in_funct7b5  in  1  instr bit 30 for ALUR, and for ALUI with funct3=101
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  byte-offset / value immediate, two's complement
- in_last  in  1  marks final descriptor of the session
- imem_we  out  1  write request
- imem_ready  in  1  memory accepts the write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this session
- done  out  1  one-cycle pulse after the last write completes
- err  out  1  sticky error flag, cleared by `start`
- err_code  out  2  01 illegal kind, 10 immediate out of range, 11 address wrap
- err_addr  out  ADDR_W  imem_addr of the first erroring word

## Operation
- FSM states:
  - IDLE: in_ready=0. `start` moves to RUN and loads addr=BASE_ADDR, count=0, err=0.
  - RUN: accepts descriptors; a write completing with last set moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. `start` in DONE takes priority and goes straight to RUN.
- `start` in RUN is ignored.
- Encoding per standard RV32I formats:
  - Opcodes: LOAD 0000011, ALUI 0010011, ALUR 0110011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Unused fields are zero. Bit 30 = in_funct7b5 for ALUR and for ALUI with funct3=101. ALUI funct3=001 forces bit 30 to 0.
- Range checks:
  - I/S/JALR: imm must fit in 12-bit signed.
  - ALUI shifts (funct3 001/101): imm must be 0..31.
  - B: 13-bit signed and even.
  - J: 21-bit signed and even.
  - U: imm[11:0]==0.
- Illegal kind writes 32'h00000000.
- An out-of-range immediate is truncated and written anyway.
- Both illegal kind and out-of-range immediate raise err. The first error wins; err_code and err_addr are frozen until `start`.
- After a completed write at address 2^ADDR_W-1, addr wraps to 0 and err_code=11 is raised, if no error is already recorded.

## Timing
- One output register stage. A descriptor accepted at edge N appears on imem_we/addr/wdata from N+1.
- The output holds stable while imem_we & !imem_ready.
- in_ready = (state==RUN) & !last_pending & (!imem_we | imem_ready). Throughput is 1 word/cycle when imem_ready=1.
- On a write completion (imem_we & imem_ready), at the same edge: addr increments and count increments.
- A new descriptor can be loaded into the output stage on the same edge a write completes.
- After a descriptor with in_last=1 is accepted, in_ready stays 0 until the session ends.
- done is asserted in the cycle after the last write completes.
- Reset values: state=IDLE, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, done=0, err=0, err_code=0, err_addr=0, in_ready=0.
- Reset asserted mid-session aborts immediately. A pending write is dropped; no partial state is retained.

## Structure
- Package `rv_enc_pkg` holds:
  - instr-kind enum
  - opcode localparams
  - err_code constants
  - NOP constant 32'h00000013
- Sub-module `rv_enc_comb`: purely combinational. Takes a descriptor; produces the 32-bit word, illegal-kind flag and immediate-range flag.
- The top level holds the FSM, output register, address/count counters and error capture.

## Test plan
- start; addi x1,x0,5 (ALUI, f3=000, imm=5) with last -> write at BASE_ADDR of 0x00500093, done pulse one cycle later, count=1.
- Back-to-back ALUR add x3,x1,x2 then sub (funct7b5=1), imem_ready=1 -> 0x002081B3 then 0x402081B3 on consecutive cycles at addresses 0 and 1.
- sw x2,8(x1) -> 0x0020A423; beq x1,x2,+8 -> 0x00208463; jal x1,+16 -> 0x010000EF; lui x5,0x12345000 -> 0x123452B7.
- Hold imem_ready=0 for 3 cycles mid-stream -> imem_addr/wdata stable, in_ready=0, no descriptor lost or duplicated.
- BRANCH imm=5 (odd) at addr 4, then illegal kind at addr 6 -> err=1, err_code=10, err_addr=4 (unchanged by the second error); word at addr 6 = 0.
- ADDR_W=2, write 5 words -> fifth write at addr 0, err_code=11; assert rst mid-stall -> all outputs at reset values next cycle.
